// File: rtl/mpu_op_sequencer.sv
// Operand sequencer: FIFO of operand pairs feeding one MPU lane over stb/ack, with a result port and a watchdog.
// Optional MPU_SEQ_STATS_EN adds completed-op and max-latency counters.
module mpu_op_sequencer #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_a,
  input  logic [DATA_W-1:0] push_b,
  output logic [DATA_W-1:0] input_a,
  output logic [DATA_W-1:0] input_b,
  output logic              input_stb,
  input  logic              input_ack,
  input  logic [DATA_W-1:0] output_z,
  input  logic              output_stb,
  output logic              output_ack,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr
`ifdef MPU_SEQ_STATS_EN
  ,
  output logic [31:0]       stat_ops,
  output logic [15:0]       stat_max_lat
`endif
);

  // state | meaning
  // IDLE  | waiting for a queued op and a free result slot
  // SEND  | operands presented, input_stb high
  // WAIT  | operands taken, waiting for output_stb
  // ACK   | output_ack pulse cycle
  typedef enum logic [1:0] {IDLE, SEND, WAIT, ACK} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic [WW-1:0]     wd_cnt;
  logic              wd_hit;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign push_ready = !full;
  assign push       = push_valid && !full;
  assign pop        = (state == IDLE) && !empty && !res_valid;
  assign wd_hit     = (wd_cnt == WW'(TIMEOUT - 1));
  assign busy       = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr[AW-1:0]] <= push_a;
      mem_b[wr_ptr[AW-1:0]] <= push_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      input_a     <= '0;
      input_b     <= '0;
      input_stb   <= 1'b0;
      output_ack  <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      timeout_err <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      output_ack <= 1'b0;
      if (err_clr) timeout_err <= 1'b0;
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            input_a   <= mem_a[rd_ptr[AW-1:0]];
            input_b   <= mem_b[rd_ptr[AW-1:0]];
            input_stb <= 1'b1;
            wd_cnt    <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (input_ack) begin
            input_stb <= 1'b0;
            wd_cnt    <= '0;
            state     <= WAIT;
          end else if (wd_hit) begin
            input_stb   <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (output_stb) begin
            res_data   <= output_z;
            res_valid  <= 1'b1;
            output_ack <= 1'b1;
            state      <= ACK;
          end else if (wd_hit) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MPU_SEQ_STATS_EN
  logic [15:0] lat_cnt;
  logic [15:0] lat_now;

  // Latency counts edges from SEND entry up to and including the capture edge.
  assign lat_now = (lat_cnt == 16'hFFFF) ? 16'hFFFF : lat_cnt + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt      <= '0;
      stat_ops     <= '0;
      stat_max_lat <= '0;
    end else begin
      if (pop) begin
        lat_cnt <= '0;
      end else if ((state == SEND || state == WAIT) && lat_cnt != 16'hFFFF) begin
        lat_cnt <= lat_cnt + 16'd1;
      end
      if (state == WAIT && output_stb) begin
        stat_ops <= stat_ops + 32'd1;
        if (lat_now > stat_max_lat) stat_max_lat <= lat_now;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mpu_op_sequencer.sv
// Directed bench for mpu_op_sequencer: handshake, FIFO full, back-pressure, watchdog, reset.
module tb_mpu_op_sequencer;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              push_valid = 1'b0;
  logic              push_ready;
  logic [DATA_W-1:0] push_a = '0;
  logic [DATA_W-1:0] push_b = '0;
  logic [DATA_W-1:0] input_a;
  logic [DATA_W-1:0] input_b;
  logic              input_stb;
  logic              input_ack = 1'b0;
  logic [DATA_W-1:0] output_z = '0;
  logic              output_stb = 1'b0;
  logic              output_ack;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [DATA_W-1:0] res_data;
  logic              busy;
  logic              timeout_err;
  logic              err_clr = 1'b0;
`ifdef MPU_SEQ_STATS_EN
  logic [31:0]       stat_ops;
  logic [15:0]       stat_max_lat;
`endif

  int checks = 0;
  int errors = 0;

  mpu_op_sequencer #(.DATA_W(DATA_W), .DEPTH(8), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready), .push_a(push_a), .push_b(push_b),
    .input_a(input_a), .input_b(input_b), .input_stb(input_stb), .input_ack(input_ack),
    .output_z(output_z), .output_stb(output_stb), .output_ack(output_ack),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
`ifdef MPU_SEQ_STATS_EN
    , .stat_ops(stat_ops), .stat_max_lat(stat_max_lat)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    push_valid = 1'b1;
    push_a     = a;
    push_b     = b;
    tick;
    push_valid = 1'b0;
  endtask

  task automatic wait_stb;
    for (int n = 0; n < 40 && input_stb !== 1'b1; n++) tick;
    chk("stb_seen", input_stb, 1);
  endtask

  // Acts as the MPU: accept operands, wait gap cycles, return z.
  task automatic serve(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] z, input int gap);
    wait_stb;
    chk("op_a", input_a, a);
    chk("op_b", input_b, b);
    input_ack = 1'b1;
    tick;
    input_ack = 1'b0;
    chk("stb_drop", input_stb, 0);
    chk("no_early_ack", output_ack, 0);
    repeat (gap) tick;
    output_z   = z;
    output_stb = 1'b1;
    tick;
    output_stb = 1'b0;
    chk("res_valid_set", res_valid, 1);
    chk("res_data", res_data, z);
    chk("ack_pulse", output_ack, 1);
  endtask

  task automatic drain;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk("ack_one_cycle", output_ack, 0);
    chk("res_drained", res_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    tick;
    tick;
    chk("rst_stb", input_stb, 0);
    chk("rst_ack", output_ack, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_res_data", res_data, 0);
    rst = 1'b0;
    tick;
    chk("idle_push_ready", push_ready, 1);

    // Basic op (3,4) -> 12, with minimum issue latency
    push(3, 4);
    chk("lat_not_yet", input_stb, 0);
    chk("busy_queued", busy, 1);
    tick;
    chk("lat_stb", input_stb, 1);
    serve(3, 4, 12, 0);
    tick;
    chk("ack_single", output_ack, 0);
    chk("res_held", res_valid, 1);
    chk("busy_done", busy, 0);

    // Fill FIFO while the previous result is still held
    for (int i = 0; i < 8; i++) begin
      push(i + 1, i + 11);
      chk("fill_ready", push_ready, (i < 7) ? 1 : 0);
    end
    push(99, 99);
    chk("full_ready", push_ready, 0);
    chk("held_no_issue", input_stb, 0);
    drain;
    for (int i = 0; i < 8; i++) begin
      serve(i + 1, i + 11, (i + 1) * (i + 11), i % 3);
      drain;
    end
    chk("ninth_dropped", busy, 0);

    // Back-pressure: second op waits for first result to drain
    push(5, 6);
    push(7, 8);
    serve(5, 6, 30, 1);
    repeat (5) tick;
    chk("bp_no_issue", input_stb, 0);
    chk("bp_res_held", res_valid, 1);
    chk("bp_busy", busy, 1);
    drain;
    serve(7, 8, 56, 0);
    drain;

    // Watchdog in SEND
    push(1, 2);
    push(2, 3);
    wait_stb;
    chk("wd_op_a", input_a, 1);
    repeat (254) tick;
    chk("wd_before_err", timeout_err, 0);
    chk("wd_before_stb", input_stb, 1);
    tick;
    chk("wd_err_set", timeout_err, 1);
    chk("wd_stb_low", input_stb, 0);
    chk("wd_no_result", res_valid, 0);
    tick;
    chk("wd_next_issued", input_stb, 1);
    chk("wd_next_a", input_a, 2);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("wd_err_clr", timeout_err, 0);
    serve(2, 3, 6, 0);
    drain;

    // Reset while in WAIT with a queued op
    push(4, 5);
    push(6, 7);
    wait_stb;
    input_ack = 1'b1;
    tick;
    input_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_stb", input_stb, 0);
    chk("mrst_ack", output_ack, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_res_data", res_data, 0);
    chk("mrst_input_a", input_a, 0);
    tick;
    rst = 1'b0;
    output_z   = 32'hDEAD;
    output_stb = 1'b1;
    tick;
    output_stb = 1'b0;
    chk("mrst_no_capture", res_valid, 0);
    chk("mrst_no_pulse", output_ack, 0);
    tick;
    chk("mrst_fifo_empty", busy, 0);
    chk("mrst_still_idle", input_stb, 0);

`ifdef MPU_SEQ_STATS_EN
    serve(1, 1, 1, 1); drain;
    serve(2, 2, 4, 5); drain;
    serve(3, 3, 9, 2); drain;
    serve(4, 4, 16, 2); drain;
    serve(5, 5, 25, 3); drain;
    chk("stat_ops", stat_ops, 5);
    chk("stat_max_lat", stat_max_lat, 7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
